// File: rtl/dual_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dual_core_mem_arbiter
//
// Purpose:
//   Shares the single BRAM port of the memory subsystem between the data
//   memory stages of NUM_CORES cores. One request is granted per cycle and
//   driven straight onto the BRAM port. The one-cycle-latency read data is
//   steered back to the granted core together with a one-cycle valid pulse.
//   Stores receive the same pulse as a write acknowledge, with zero data.
//
// Build option:
//   MEM_ARB_FIXED_PRIORITY_EN - when defined, the lowest-index requesting
//   core always wins and no priority pointer exists. When undefined (the
//   default), round-robin priority is used.
//
// Parameters:
//   NUM_CORES        number of requesting cores (2..8)
//   DATA_WIDTH       data word width
//   ADDRESS_BITS     core byte-address width
//   MEM_ADDRESS_BITS BRAM word-address width
//
// Ports (packed buses, core i occupies slice [i*W +: W]):
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req_valid    in   per-core request, held until granted
//   req_write    in   per-core 1 = store, 0 = load
//   req_address  in   per-core byte address
//   req_data     in   per-core store data
//   req_ready    out  one-hot grant, combinational, same cycle as issue
//   resp_valid   out  one-hot response, one cycle after the grant
//   resp_data    out  per-core load data, zero unless responding to a load
//   bram_en      out  BRAM access enable
//   bram_we      out  BRAM write enable
//   bram_addr    out  BRAM word address
//   bram_wdata   out  BRAM write data
//   bram_rdata   in   BRAM read data, one-cycle latency
// -----------------------------------------------------------------------------
module dual_core_mem_arbiter #(
  parameter int NUM_CORES        = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              req_valid,
  input  logic [NUM_CORES-1:0]              req_write,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] req_address,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_CORES-1:0]              req_ready,
  output logic [NUM_CORES-1:0]              resp_valid,
  output logic [NUM_CORES*DATA_WIDTH-1:0]   resp_data,
  output logic                              bram_en,
  output logic                              bram_we,
  output logic [MEM_ADDRESS_BITS-1:0]       bram_addr,
  output logic [DATA_WIDTH-1:0]             bram_wdata,
  input  logic [DATA_WIDTH-1:0]             bram_rdata
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Current highest-priority core.
  logic [PTR_W-1:0] ptr_s;

  // Grant search results.
  logic             gnt_found_s;
  logic [PTR_W-1:0] gnt_idx_s;
  logic             grant_s;

  // Response tracking registers.
  logic             resp_pend_q;
  logic             resp_pend_d;
  logic [PTR_W-1:0] resp_core_q;
  logic [PTR_W-1:0] resp_core_d;
  logic             resp_we_q;
  logic             resp_we_d;

  // Address bits outside the word index are intentionally discarded.
  logic unused_addr_s;
  assign unused_addr_s = ^req_address;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: search always starts at core 0.
  assign ptr_s = {PTR_W{1'b0}};
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next priority pointer: one past the granted core, wrapping at NUM_CORES.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s) begin
      if (gnt_idx_s == PTR_W'(NUM_CORES - 1)) begin
        ptr_d = {PTR_W{1'b0}};
      end else begin
        ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= {PTR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`endif

  // Rotating search from ptr_s: first requesting core in modular order wins.
  always_comb begin
    logic [PTR_W:0] cand_s;
    gnt_found_s = 1'b0;
    gnt_idx_s   = {PTR_W{1'b0}};
    cand_s      = {(PTR_W+1){1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_s = {1'b0, ptr_s} + (PTR_W+1)'(k);
      if (cand_s >= (PTR_W+1)'(NUM_CORES)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_CORES);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && req_valid[cand_s[PTR_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // No grant may be issued while reset is asserted.
  assign grant_s = gnt_found_s && !reset;

  // Grant vector and BRAM port mux; everything is zero when nothing is granted.
  always_comb begin
    req_ready  = {NUM_CORES{1'b0}};
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = {MEM_ADDRESS_BITS{1'b0}};
    bram_wdata = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_s && (gnt_idx_s == PTR_W'(i))) begin
        req_ready[i] = 1'b1;
        bram_en      = 1'b1;
        bram_we      = req_write[i];
        // Word index: drop the byte offset and alias modulo the BRAM depth.
        bram_addr    = req_address[i*ADDRESS_BITS + 2 +: MEM_ADDRESS_BITS];
        bram_wdata   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Capture what was issued this cycle so the response can be routed next cycle.
  always_comb begin
    resp_pend_d = grant_s;
    resp_core_d = gnt_idx_s;
    resp_we_d   = bram_we;
  end

  // Response tracking registers; reset drops any in-flight response.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pend_q <= 1'b0;
      resp_core_q <= {PTR_W{1'b0}};
      resp_we_q   <= 1'b0;
    end else begin
      resp_pend_q <= resp_pend_d;
      resp_core_q <= resp_core_d;
      resp_we_q   <= resp_we_d;
    end
  end

  // Response steering: valid pulse to the owner, read data only for loads.
  always_comb begin
    resp_valid = {NUM_CORES{1'b0}};
    resp_data  = {(NUM_CORES*DATA_WIDTH){1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (resp_pend_q && !reset && (resp_core_q == PTR_W'(i))) begin
        resp_valid[i] = 1'b1;
        if (!resp_we_q) begin
          resp_data[i*DATA_WIDTH +: DATA_WIDTH] = bram_rdata;
        end else begin
          resp_data[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        end
      end else begin
        resp_valid[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dual_core_mem_arbiter
//
// Directed bench for dual_core_mem_arbiter in its default (round-robin) build.
// A small write-first BRAM model with one-cycle read latency sits on the BRAM
// port. Inputs change one time unit after the rising edge; outputs are sampled
// one further time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dual_core_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_address;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [63:0] resp_data;
  logic        bram_en;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:16383];

  dual_core_mem_arbiter #(
    .NUM_CORES       (2),
    .DATA_WIDTH      (32),
    .ADDRESS_BITS    (32),
    .MEM_ADDRESS_BITS(14)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_address(req_address),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first BRAM model with registered read data.
  always @(posedge clock) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_wdata;
        bram_rdata     <= bram_wdata;
      end else begin
        bram_rdata <= mem[bram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    mem[5]  = 32'd2000;
    mem[10] = 32'd2050;
    mem[50] = 32'd2000;
    mem[51] = 32'd2050;
    mem[64] = 32'd0;
    bram_rdata  = 32'd0;
    reset       = 1'b1;
    req_valid   = 2'b00;
    req_write   = 2'b00;
    req_address = 64'd0;
    req_data    = 64'd0;

    // Reset: grants forced off even with requests present.
    step();
    step();
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_en", 64'(bram_en), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    req_valid = 2'b00;
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_rst_resp_data", resp_data, 64'd0);
    chk("post_rst_addr", 64'(bram_addr), 64'd0);
    chk("post_rst_wdata", 64'(bram_wdata), 64'd0);

    // Single load: core 0 at 0x28 (word 10 = 2050).
    req_valid   = 2'b01;
    req_address = {32'h0, 32'h28};
    #1;
    chk("ld_ready", 64'(req_ready), 64'h1);
    chk("ld_en", 64'(bram_en), 64'd1);
    chk("ld_we", 64'(bram_we), 64'd0);
    chk("ld_addr", 64'(bram_addr), 64'd10);
    step();
    req_valid = 2'b00;
    #1;
    chk("ld_resp_valid", 64'(resp_valid), 64'h1);
    chk("ld_resp_data", resp_data, {32'd0, 32'd2050});
    chk("ld_idle_ready", 64'(req_ready), 64'd0);
    step();

    // Contention: pointer is now 1 so core 1 (0xCC, word 51 = 2050) goes first.
    req_valid   = 2'b11;
    req_address = {32'hCC, 32'h14};
    #1;
    chk("cont0_ready", 64'(req_ready), 64'h2);
    chk("cont0_addr", 64'(bram_addr), 64'd51);
    chk("cont0_resp_valid", 64'(resp_valid), 64'd0);
    step();
    chk("cont1_ready", 64'(req_ready), 64'h1);
    chk("cont1_addr", 64'(bram_addr), 64'd5);
    chk("cont1_resp_valid", 64'(resp_valid), 64'h2);
    chk("cont1_resp_data", resp_data, {32'd2050, 32'd0});
    step();
    chk("cont2_ready", 64'(req_ready), 64'h2);
    chk("cont2_resp_valid", 64'(resp_valid), 64'h1);
    chk("cont2_resp_data", resp_data, {32'd0, 32'd2000});
    step();
    chk("cont3_ready", 64'(req_ready), 64'h1);
    chk("cont3_resp_valid", 64'(resp_valid), 64'h2);
    chk("cont3_resp_data", resp_data, {32'd2050, 32'd0});
    step();

    // Store 0xDEADBEEF to 0x100 from core 1 (last contention response is core 0).
    req_valid   = 2'b10;
    req_write   = 2'b10;
    req_address = {32'h100, 32'h0};
    req_data    = {32'hDEADBEEF, 32'h0};
    #1;
    chk("st_resp_valid_prev", 64'(resp_valid), 64'h1);
    chk("st_resp_data_prev", resp_data, {32'd0, 32'd2000});
    chk("st_ready", 64'(req_ready), 64'h2);
    chk("st_we", 64'(bram_we), 64'd1);
    chk("st_addr", 64'(bram_addr), 64'd64);
    chk("st_wdata", 64'(bram_wdata), 64'hDEADBEEF);
    step();
    req_write = 2'b00;
    #1;
    chk("raw_ready", 64'(req_ready), 64'h2);
    chk("raw_we", 64'(bram_we), 64'd0);
    chk("raw_addr", 64'(bram_addr), 64'd64);
    chk("st_ack_valid", 64'(resp_valid), 64'h2);
    chk("st_ack_data", resp_data, 64'd0);
    step();
    req_valid = 2'b00;
    req_data  = 64'd0;
    #1;
    chk("raw_resp_valid", 64'(resp_valid), 64'h2);
    chk("raw_resp_data", resp_data, {32'hDEADBEEF, 32'd0});
    chk("raw_idle_en", 64'(bram_en), 64'd0);
    chk("raw_idle_addr", 64'(bram_addr), 64'd0);
    step();

    // Aliasing: 0x0001_002B maps to word 10.
    req_valid   = 2'b01;
    req_address = {32'h0, 32'h0001_002B};
    #1;
    chk("alias_ready", 64'(req_ready), 64'h1);
    chk("alias_addr", 64'(bram_addr), 64'd10);
    step();
    req_valid = 2'b00;
    #1;
    chk("alias_resp_valid", 64'(resp_valid), 64'h1);
    chk("alias_resp_data", resp_data, {32'd0, 32'd2050});
    step();

    // Reset mid-operation: pointer would be 1 without the reset.
    req_valid   = 2'b01;
    req_address = {32'h0, 32'h28};
    #1;
    chk("rmid_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rmid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rmid_resp_data", resp_data, 64'd0);
    req_valid   = 2'b11;
    req_address = {32'hCC, 32'h14};
    #1;
    chk("rmid_first_grant", 64'(req_ready), 64'h1);
    step();
    chk("rmid_g1", 64'(req_ready), 64'h2);
    chk("rmid_r1", 64'(resp_valid), 64'h1);
    step();
    chk("rmid_g2", 64'(req_ready), 64'h1);
    chk("rmid_r2_data", resp_data, {32'd2050, 32'd0});
    step();
    req_valid = 2'b00;
    #1;
    chk("rmid_r3", 64'(resp_valid), 64'h1);
    step();

    // Idle: 20 cycles with no requests; pointer must stay at 1.
    for (int i = 0; i < 20; i++) begin
      chk("idle_ready", 64'(req_ready), 64'd0);
      chk("idle_en", 64'(bram_en), 64'd0);
      chk("idle_resp_valid", 64'(resp_valid), 64'd0);
      step();
    end
    req_valid = 2'b11;
    #1;
    chk("idle_ptr_kept", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_core_mem_arbiter.md
# dual_core_mem_arbiter

Arbitrates the per-core data-memory requests of the dual-core single-cycle processor onto the single shared BRAM port inside the memory subsystem. Grants one request per cycle using round-robin priority and issues it to the BRAM. Steers the one-cycle-latency read data back to the requesting core with a valid pulse. Sits between the cores' memory stage and `memory.BRAM_inst`.

## Interface
- `NUM_CORES`, 2: number of requesting cores; legal range 2..8.
- `DATA_WIDTH`, 32: data word width.
- `ADDRESS_BITS`, 32: core byte-address width.
- `MEM_ADDRESS_BITS`, 14: BRAM word-address width.

Ports (packed buses: core i occupies slice `[i*W +: W]`):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_CORES  core i requests; held until granted.
- `req_write`  in  NUM_CORES  1 = store, 0 = load.
- `req_address`  in  NUM_CORES*ADDRESS_BITS  byte addresses.
- `req_data`  in  NUM_CORES*DATA_WIDTH  store data.
- `req_ready`  out  NUM_CORES  one-hot grant; combinational, same cycle as issue.
- `resp_valid`  out  NUM_CORES  one-hot, one cycle after grant.
- `resp_data`  out  NUM_CORES*DATA_WIDTH  load data; valid only with `resp_valid`.
- `bram_en`  out  1  BRAM access enable.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  MEM_ADDRESS_BITS  BRAM word address.
- `bram_wdata`  out  DATA_WIDTH  BRAM write data.
- `bram_rdata`  in  DATA_WIDTH  BRAM read data, registered inside BRAM, one-cycle latency.

## Operation
- Priority pointer `ptr` (log2 NUM_CORES bits) names the highest-priority core. Search order: ptr, ptr+1, ..., wrapping modulo NUM_CORES.
- Grant: the first core in search order with `req_valid`=1 receives `req_ready`=1. At most one grant per cycle.
- On a grant, `bram_en`=1 and `bram_we`=`req_write[g]`. `bram_addr` = `req_address[g][MEM_ADDRESS_BITS+1:2]`, and `bram_wdata`=`req_data[g]`.
- Address bits [1:0] are ignored, so access is word-aligned. Bits above MEM_ADDRESS_BITS+1 are ignored, so the address aliases modulo 2^MEM_ADDRESS_BITS words.
- On a grant, `ptr` <= g+1 mod NUM_CORES. When there is no grant, `ptr` holds.
- Response register: `resp_core` and `resp_pend` capture g and grant. In the next cycle, `resp_valid[resp_core]`=1.
  - For a load, `resp_data` slice = `bram_rdata`.
  - For a store, `resp_valid` pulses as a write acknowledge and `resp_data` slice = 0.
- Non-responding `resp_data` slices are 0.
- Cores must hold `req_*` stable until `req_ready`. Deasserting `req_valid` before grant is legal and cancels the request.
- When no request is pending, `bram_en`=0, `bram_we`=0, `bram_addr`=0 and `bram_wdata`=0.

## Timing
- Reset values: `ptr`=0 and `resp_pend`=0. All outputs are 0 while `reset`=1 and in the first cycle after release, unless a request is present.
- `req_ready` is combinational from `req_valid` and `ptr`, and is forced to 0 during reset.
- Load latency is grant cycle N to `resp_valid` and data in cycle N+1. Back-to-back grants are allowed, giving full throughput of one access per cycle.
- Both cores requesting continuously: grants alternate 0,1,0,1,..., starting from the `ptr` value.
- A single requester is granted every cycle with no idle bubble.
- Read-after-write to the same word in consecutive cycles: the read returns the newly written data. This relies on the BRAM write-first behaviour and the arbiter adds no bypass.
- Reset asserted while a response is pending: `resp_valid` is 0 in the following cycle and the response is dropped. `ptr` returns to 0.

## Configuration
- `MEM_ARB_FIXED_PRIORITY_EN`:
  - Defined: the lowest-index requesting core always wins. `ptr` is not implemented (constant 0) and a core can be starved.
  - Undefined (default): round-robin as above.
- Latency and response behaviour are identical in both modes.

## Test plan
- Single load: core 0 requests load at 0x28, with BRAM word 10 = 2050.
  - Cycle N: `req_ready`=01, `bram_addr`=10.
  - Cycle N+1: `resp_valid`=01, `resp_data[0+:32]`=2050.
- Contention: both cores load continuously; core 0 at 0x14 (word 5 = 2000), core 1 at 0xC8 (word 50 = 2000 with word 51 = 2050, address 0xCC).
  - Grants alternate 01,10,01,10 and responses alternate likewise, one cycle later.
  - With the macro defined, grant stays 01 every cycle.
- Store then load: core 1 stores 0xDEADBEEF to 0x100, then loads 0x100 the next cycle.
  - `bram_we`=1 with `bram_addr`=64, then a write ack.
  - The load response is 0xDEADBEEF.
- Aliasing and alignment: core 0 loads 0x0001_002B.
  - `bram_addr`=10 (bits 15:2 of 0x1002B = 0x400A, masked to 14 bits = 10) and data 2050.
- Reset mid-operation: grant a load in cycle N, assert `reset` in cycle N+1.
  - `resp_valid`=0 after the reset edge and `ptr`=0.
  - The first post-reset contention grants core 0.
- Idle: no requests for 20 cycles.
  - `bram_en`=0 and `req_ready`=0 throughout, with `ptr` unchanged.
